// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters, sync pulses, visible-area flag and
// frame-aligned run/stop control, all advanced by a pixel-rate enable.
module vga_timing_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned SYNC_POL  = 0,
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned XW       = $clog2(H_TOTAL),
    localparam int unsigned YW       = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          pix_tick,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam logic [XW-1:0] X_LAST  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_TOTAL - 1);
    localparam logic [XW:0]   H_VIS_B = (XW+1)'(H_VISIBLE);
    localparam logic [XW:0]   H_SS    = (XW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [XW:0]   H_SE    = (XW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [YW:0]   V_VIS_B = (YW+1)'(V_VISIBLE);
    localparam logic [YW:0]   V_SS    = (YW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [YW:0]   V_SE    = (YW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic          SYNC_ACT = 1'(SYNC_POL);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_running;

    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_stop;
    logic          w_load;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_vis;

    // Next count value; entering RUN from IDLE always loads (0,0).
    always_comb begin
        w_x_last = (r_x == X_LAST);
        w_y_last = (r_y == Y_LAST);
        w_nx     = '0;
        w_ny     = '0;
        if (r_state == ST_RUN) begin
            w_nx = w_x_last ? '0 : r_x + XW'(1);
            w_ny = r_y;
            if (w_x_last) begin
                w_ny = w_y_last ? '0 : r_y + YW'(1);
            end
        end
        w_stop  = pix_tick && (r_state == ST_RUN) && w_x_last && w_y_last && !enable;
        w_load  = pix_tick && ((r_state == ST_RUN) || enable) && !w_stop;
        w_hs_on = ({1'b0, w_nx} >= H_SS) && ({1'b0, w_nx} < H_SE);
        w_vs_on = ({1'b0, w_ny} >= V_SS) && ({1'b0, w_ny} < V_SE);
        w_vis   = ({1'b0, w_nx} < H_VIS_B) && ({1'b0, w_ny} < V_VIS_B);
    end

    // State, counters and decodes all update together so they stay aligned.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~SYNC_ACT;
            r_vsync       <= ~SYNC_ACT;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_stop) begin
                r_x        <= '0;
                r_y        <= '0;
                r_hsync    <= ~SYNC_ACT;
                r_vsync    <= ~SYNC_ACT;
                r_video_on <= 1'b0;
                r_running  <= 1'b0;
            end else if (w_load) begin
                r_x           <= w_nx;
                r_y           <= w_ny;
                r_hsync       <= w_hs_on ? SYNC_ACT : ~SYNC_ACT;
                r_vsync       <= w_vs_on ? SYNC_ACT : ~SYNC_ACT;
                r_video_on    <= w_vis;
                r_line_start  <= (w_nx == '0);
                r_frame_start <= (w_nx == '0) && (w_ny == '0);
                r_running     <= 1'b1;
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = r_running;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small raster checked against a linear-index
// reference model, plus a short run of the default 640x480 timing.
module tb_vga_timing_ctrl;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam bit SP = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small-raster instance
    logic       a_reset = 1'b1, a_tick = 1'b0, a_en = 1'b0;
    logic       a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_running;
    logic [2:0] a_x, a_y;

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0)
    ) u_small (
        .clk_in(clk), .reset(a_reset), .pix_tick(a_tick), .enable(a_en),
        .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .pixel_x(a_x), .pixel_y(a_y),
        .line_start(a_line_start), .frame_start(a_frame_start), .running(a_running)
    );

    // Default-timing instance
    logic       b_reset = 1'b1, b_tick = 1'b0, b_en = 1'b0;
    logic       b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start, b_running;
    logic [9:0] b_x, b_y;

    vga_timing_ctrl u_vga (
        .clk_in(clk), .reset(b_reset), .pix_tick(b_tick), .enable(b_en),
        .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
        .pixel_x(b_x), .pixel_y(b_y),
        .line_start(b_line_start), .frame_start(b_frame_start), .running(b_running)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: running flag plus linear pixel index within the frame
    bit m_run = 1'b0;
    int m_pos = 0;
    bit m_ls  = 1'b0;
    bit m_fs  = 1'b0;

    function automatic logic [11:0] pk(input logic hs, input logic vs, input logic vo,
                                       input logic ls, input logic fs, input logic run,
                                       input int x, input int y);
        return {hs, vs, vo, ls, fs, run, 3'(x), 3'(y)};
    endfunction

    function automatic logic [11:0] model_outs();
        int  x;
        int  y;
        bit  hs_act;
        bit  vs_act;
        bit  vo;
        x      = m_pos % HT;
        y      = m_pos / HT;
        hs_act = m_run && (x >= HV + HF) && (x < HV + HF + HS);
        vs_act = m_run && (y >= VV + VF) && (y < VV + VF + VS);
        vo     = m_run && (x < HV) && (y < VV);
        return pk(hs_act ? SP : ~SP, vs_act ? SP : ~SP, vo, m_ls, m_fs, m_run, x, y);
    endfunction

    function automatic logic [11:0] a_outs();
        return {a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_running, a_x, a_y};
    endfunction

    task automatic step(input logic r, input logic t, input logic e);
        a_reset = r;
        a_tick  = t;
        a_en    = e;
        @(posedge clk);
        #1;
        cyc++;
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (r) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            if (t && e) begin
                m_run = 1'b1; m_pos = 0; m_ls = 1'b1; m_fs = 1'b1;
            end
        end else if (t) begin
            if (m_pos == HT * VT - 1) begin
                m_pos = 0;
                if (e) begin
                    m_ls = 1'b1; m_fs = 1'b1;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_pos++;
                m_ls = (m_pos % HT == 0);
            end
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual{hs,vs,vo,ls,fs,run,x,y}=%b required=%b",
                     name, cyc, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    typedef struct {
        logic        r;
        logic        t;
        logic        e;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [11:0] idle_o;
    int          times[$];
    logic        e_rand;
    int          cnt_ls, cnt_fs, cnt_hs, cnt_vs, cnt_vo;

    initial begin
        idle_o   = pk(1, 1, 0, 0, 0, 0, 0, 0);
        vecs[0]  = '{1'b1, 1'b1, 1'b1, idle_o};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, idle_o};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 1, 1, 1, 0, 0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, pk(1, 1, 1, 0, 0, 1, 0, 0)};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 0, 0, 1, 1, 0)};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 0, 0, 1, 2, 0)};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, pk(1, 1, 1, 0, 0, 1, 3, 0)};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, pk(1, 1, 0, 0, 0, 1, 4, 0)};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, pk(0, 1, 0, 0, 0, 1, 5, 0)};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, pk(0, 1, 0, 0, 0, 1, 6, 0)};
        vecs[10] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 0, 0, 0, 1, 7, 0)};
        vecs[11] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 1, 0, 1, 0, 1)};
        vecs[12] = '{1'b1, 1'b1, 1'b1, idle_o};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].e);
            check($sformatf("vec%0d", i), a_outs(), vecs[i].exp);
        end

        // Stop at frame end: enable drops at (2,1), frame still completes
        step(1'b0, 1'b1, 1'b1);
        check("stop_enter", a_outs(), model_outs());
        for (int k = 0; k < 47; k++) begin
            step(1'b0, 1'b1, (m_pos < HT + 2) ? 1'b1 : 1'b0);
            check("stop_run", a_outs(), model_outs());
        end
        check_int("stop_last_x", int'(a_x), 7);
        check_int("stop_last_y", int'(a_y), 5);
        check_int("stop_last_run", int'(a_running), 1);
        step(1'b0, 1'b1, 1'b0);
        check("stop_idle", a_outs(), idle_o);
        step(1'b0, 1'b1, 1'b0);
        check("stop_hold", a_outs(), idle_o);

        // Drop at (2,1), re-raise at (3,4): the stop is cancelled
        step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 47; k++) begin
            step(1'b0, 1'b1, (m_pos < HT + 2 || m_pos >= 4 * HT + 3) ? 1'b1 : 1'b0);
            check("cancel_run", a_outs(), model_outs());
        end
        step(1'b0, 1'b1, 1'b1);
        check("cancel_wrap", a_outs(), pk(1, 1, 1, 1, 1, 1, 0, 0));

        // Reset mid-frame at (6,4)
        for (int k = 0; k < 38; k++) step(1'b0, 1'b1, 1'b1);
        check("pre_reset_pos", a_outs(), pk(0, 0, 0, 0, 0, 1, 6, 4));
        step(1'b1, 1'b1, 1'b1);
        check("midframe_reset", a_outs(), idle_o);

        // Tick every cycle: frame_start period
        times.delete();
        for (int k = 0; k < 150; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check("full_rate", a_outs(), model_outs());
            if (a_frame_start) times.push_back(cyc);
        end
        check_int("fs_count", times.size(), 4);
        for (int i = 1; i < times.size(); i++)
            check_int("fs_period", times[i] - times[i-1], 48);
        step(1'b1, 1'b0, 1'b0);

        // Tick every 5th cycle: line_start period and width
        times.delete();
        step(1'b0, 1'b1, 1'b1);
        if (a_line_start) times.push_back(cyc);
        for (int k = 1; k <= 200; k++) begin
            step(1'b0, (k % 5 == 0) ? 1'b1 : 1'b0, 1'b1);
            check("slow_tick", a_outs(), model_outs());
            if (a_line_start) times.push_back(cyc);
        end
        check_int("ls_count", times.size(), 6);
        for (int i = 1; i < times.size(); i++)
            check_int("ls_period", times[i] - times[i-1], 40);

        // Random ticks, enable toggles and occasional resets vs. the model
        e_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) e_rand = ~e_rand;
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, e_rand);
            check("random", a_outs(), model_outs());
        end

        // Default 640x480 timing: three full lines at one pixel per clock
        a_reset = 1'b1;
        check_int("vga_reset_state",
                  int'({b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start, b_running}),
                  int'(6'b110000));
        b_reset = 1'b0;
        b_tick  = 1'b1;
        b_en    = 1'b1;
        cnt_ls = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_vo = 0;
        for (int k = 0; k < 3 * 800; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            cnt_ls += int'(b_line_start);
            cnt_fs += int'(b_frame_start);
            cnt_hs += int'(!b_hsync);
            cnt_vs += int'(!b_vsync);
            cnt_vo += int'(b_video_on);
        end
        check_int("vga_line_starts", cnt_ls, 3);
        check_int("vga_frame_starts", cnt_fs, 1);
        check_int("vga_hsync_ticks", cnt_hs, 3 * 96);
        check_int("vga_video_on_ticks", cnt_vo, 3 * 640);
        check_int("vga_vsync_ticks", cnt_vs, 0);
        check_int("vga_final_x", int'(b_x), 799);
        check_int("vga_final_y", int'(b_y), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
